// File: rtl/edge_event_pkg.sv
// Shared encodings for the edge event arbiter: per-channel detect modes
// and the offer FSM states.
package edge_event_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_RISE  = 2'd1,
    MODE_FALL  = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/edge_event_detect.sv
// One channel of line history plus edge/pulse detection. The detect output
// is combinational and valid in the cycle the qualifying sample is present.
module edge_event_detect
  import edge_event_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  input  logic [1:0] mode,
  output logic       det
);

  logic l_r;
  logic l_r2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_r  <= 1'b0;
      l_r2 <= 1'b0;
    end else begin
      l_r  <= line;
      l_r2 <= l_r;
    end
  end

  // A one-cycle pulse (010) is only recognised once it has ended.
  always_comb begin
    det = 1'b0;
    case (mode_e'(mode))
      MODE_RISE:  det = line & ~l_r;
      MODE_FALL:  det = ~line & l_r;
      MODE_PULSE: det = ~line & l_r & ~l_r2;
      default:    det = 1'b0;
    endcase
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel edge events as pending flags and hands them one at a
// time to a single consumer in round-robin order.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     lines,
  input  logic [2*N-1:0]   mode,
  output logic             out_valid,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready,
  output logic [N-1:0]     ovf,
  input  logic [N-1:0]     ovf_clr
);

  // Handshake: an event transfers on a clock edge where out_valid and
  // out_ready are both 1; out_id is stable while out_valid is high and
  // out_valid only falls after such a transfer.

  state_e           state;
  logic [N-1:0]     det;
  logic [N-1:0]     mode_on;
  logic [N-1:0]     pending;
  logic [N-1:0]     pending_nxt;
  logic [N-1:0]     ovf_nxt;
  logic [N-1:0]     grant_clr;
  logic [N-1:0]     keep;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [IDW:0]     cand;

  for (genvar i = 0; i < N; i++) begin : g_ch
    edge_event_detect u_detect (
      .clk  (clk),
      .rst  (rst),
      .line (lines[i]),
      .mode (mode[2*i +: 2]),
      .det  (det[i])
    );
    assign mode_on[i] = (mode[2*i +: 2] != MODE_OFF);
  end

  // First pending channel at or after ptr, wrapping modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!grant_found && pending[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign ptr_nxt   = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
  assign grant_clr = (state == IDLE && grant_found) ? (N'(1) << grant_idx) : '0;

  // A fresh detect beats the grant clear; it only overflows when the flag
  // would otherwise have survived the edge.
  assign keep        = pending & ~grant_clr;
  assign pending_nxt = mode_on & (det | keep);
  assign ovf_nxt     = (det & keep) | (ovf & ~ovf_clr);

  assign out_valid = (state == OFFER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      out_id  <= '0;
      ptr     <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
      case (state)
        IDLE: begin
          if (grant_found) begin
            state  <= OFFER;
            out_id <= grant_idx;
            ptr    <= ptr_nxt;
          end
        end
        OFFER: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the event rules.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     lines = '0;
  logic [2*N-1:0]   mode = '0;
  logic             out_valid;
  logic [IDW-1:0]   out_id;
  logic             out_ready = 1'b0;
  logic [N-1:0]     ovf;
  logic [N-1:0]     ovf_clr = '0;

  // clock / reset
  always #5 clk = ~clk;

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .lines     (lines),
    .mode      (mode),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: previous samples, pending set, overflow set, offer
  bit h1[N], h2[N], pend[N], m_ovf[N];
  bit m_valid;
  int m_id, m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      h1[i] = 0; h2[i] = 0; pend[i] = 0; m_ovf[i] = 0;
    end
    m_valid = 0; m_id = 0; m_ptr = 0;
  endfunction

  function automatic void model_edge();
    bit det;
    bit cur;
    int md;
    int g;
    g = -1;
    if (!m_valid)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      cur = lines[i];
      md  = int'(mode[2*i +: 2]);
      case (md)
        1: det = cur && !h1[i];
        2: det = !cur && h1[i];
        3: det = !cur && h1[i] && !h2[i];
        default: det = 0;
      endcase
      m_ovf[i] = (det && pend[i] && g != i) || (m_ovf[i] && !ovf_clr[i]);
      pend[i]  = (md != 0) && (det || (pend[i] && g != i));
      h2[i] = h1[i];
      h1[i] = cur;
    end
    if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_ptr   = (g + 1) % N;
    end
  endfunction

  // scoreboard: delivered ids vs expected id sequence
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] hs_q[$];

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // driver: one clock, inputs already set; compare at the falling edge
  task automatic tick();
    if (out_valid === 1'b1 && out_ready) hs_q.push_back(out_id);
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check("valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) check("id", 32'(out_id), 32'(m_id));
    check("ovf", 32'(ovf), 32'(model_ovf()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [N-1:0] l, input logic [2*N-1:0] m, input logic rdy);
    rst = 1'b0;
    model_reset();
    lines = l; mode = m; out_ready = rdy; ovf_clr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, 32'(hs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      check(tag, 32'(hs_q[i]), 32'(exp_q[i]));
  endtask

  logic [15:0] pat;
  logic [6:0]  oseq;

  initial begin
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);

    // rising, single event
    do_reset('0, 8'h55, 1'b1);
    ticks(3);
    lines[2] = 1'b1;
    tick(); check("rise_c0", 32'(out_valid), 32'd0);
    tick(); check("rise_c1", 32'(out_valid), 32'd1); check("rise_id", 32'(out_id), 32'd2);
    tick(); check("rise_c2", 32'(out_valid), 32'd0);
    ticks(2);
    check("rise_ovf", 32'(ovf), 32'd0);

    // round-robin order, then ptr wrapped back to 0
    do_reset('0, 8'h55, 1'b1);
    tick();
    lines = 4'b1011;
    ticks(8);
    lines = 4'b0000;
    ticks(2);
    lines = 4'b1001;
    ticks(6);
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
    check_seq("rr");

    // pulse mode on channel 1
    pat = 16'b1001011011110001;
    do_reset({2'b00, pat[15], 1'b0}, 8'b00_00_11_00, 1'b1);
    for (int k = 0; k < 16; k++) begin
      lines[1] = pat[15-k];
      tick();
    end
    ticks(6);
    exp_q = '{2'd1, 2'd1};
    check_seq("pulse");

    // overflow while the consumer stalls
    oseq = 7'b0101010;
    do_reset('0, 8'b00_00_00_01, 1'b0);
    for (int k = 0; k < 7; k++) begin
      lines[0] = oseq[6-k];
      tick();
    end
    ticks(2);
    check("ovf_set", 32'(ovf[0]), 32'd1);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = '0;
    check("ovf_clr", 32'(ovf[0]), 32'd0);
    out_ready = 1'b1;
    ticks(6);
    exp_q = '{2'd0, 2'd0};
    check_seq("ovf_seq");

    // falling vs disabled; disabling drops a pending event
    do_reset(4'b1100, 8'b00_10_01_00, 1'b1);
    ticks(2);
    lines = 4'b0000;
    ticks(6);
    out_ready = 1'b0;
    lines[1] = 1'b1;
    ticks(3);
    lines[2] = 1'b1;
    tick();
    lines[2] = 1'b0;
    tick();
    mode[5:4] = 2'd0;
    tick();
    mode[5:4] = 2'd2;
    tick();
    out_ready = 1'b1;
    ticks(6);
    exp_q = '{2'd2, 2'd1};
    check_seq("fall_dis");

    // asynchronous reset in the middle of an offer
    do_reset('0, 8'h55, 1'b0);
    tick();
    lines = 4'b0001;
    ticks(3);
    lines = 4'b1011;
    ticks(2);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    model_reset();
    lines = '0;
    @(negedge clk);
    rst = 1'b1;
    hs_q.delete();
    ticks(6);
    lines = 4'b1010;
    out_ready = 1'b1;
    ticks(8);
    exp_q = '{2'd1, 2'd3};
    check_seq("arst_seq");

    // random traffic against the model
    do_reset(4'($urandom), 8'($urandom), 1'b1);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 2) == 0) lines = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Watches N single-bit status lines, each with its own event-detect mode: rising edge, falling edge or one-cycle pulse (010).
- Records each detected event as a per-channel pending flag.
- Hands pending events one at a time to a single shared consumer over a valid/ready interface, in round-robin order.
- Sits between the synchronised status lines and the event-handling logic that consumes them.

Parameters:
- N, 4, number of input channels (2..16).
- IDW, $clog2(N), width of out_id.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- lines  in  N  status lines, already synchronous to clk.
- mode  in  2*N  per-channel mode: 0 disabled, 1 rising, 2 falling, 3 one-cycle pulse (010).
- out_valid  out  1  event offered to consumer.
- out_id  out  IDW  channel index of the offered event.
- out_ready  in  1  consumer accepts the event.
- ovf  out  N  sticky per-channel overflow flags.
- ovf_clr  in  N  per-channel overflow clear, one-cycle pulse.

Behaviour:
- Reset (rst=0, async): clears out_valid, out_id, ovf, pending, history regs l_r/l_r2 and round-robin pointer ptr. FSM goes to IDLE.
- Lines history resets to 0, so a line already high at reset release gives a rising event on its first sampled cycle.
- History: l_r <= lines and l_r2 <= l_r every cycle.
- Detect (combinational, per channel):
  - rise = lines & ~l_r
  - fall = ~lines & l_r
  - pulse = l_r & ~lines & ~l_r2, i.e. detected the cycle after the pulse ends.
  - mode 0: no detection.
- Pending: a detect in cycle t sets pending[i] at the clk edge ending t.
- Overflow: a detect while pending[i] is already 1 sets ovf[i]. pending stays 1 and the event is lost.
- Simultaneous grant-clear and detect on the same channel: pending stays 1 and there is no overflow (set wins).
- ovf_clr[i]=1 clears ovf[i]. A simultaneous new overflow on the same channel wins (ovf stays 1).
- mode[i]=0 clears pending[i] next edge. It does not affect ovf or an event already being offered.
- FSM:
  - IDLE: if any pending, grant the first set index at or after ptr, wrapping modulo N. Load out_id, clear that pending bit, set ptr = (granted+1) mod N, go to OFFER.
  - OFFER: out_valid=1, out_id held stable. On out_ready=1, drop out_valid next edge and return to IDLE.
- out_valid/out_id are registered. out_valid never drops without a handshake.
- Latency: line edge to out_valid is 2 cycles (detect cycle, then pending, then grant register). Minimum spacing between offers is 2 cycles (one IDLE bubble).
- A new detect on the channel currently being offered sets pending normally, with no overflow.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package edge_event_pkg: mode encoding enum (MODE_OFF, MODE_RISE, MODE_FALL, MODE_PULSE) and FSM state enum (IDLE, OFFER).
- One sub-module, edge_event_detect: a per-channel history/detect slice instantiated N times with generate. Inputs line and mode; output det.
- Round-robin pick and FSM live in the top.

Test Plan:
- Rising, single event:
  - Stimulus: all modes=1, out_ready=1, lines[2] 0→1 sampled in cycle 10.
  - Required: out_valid=1, out_id=2 in cycle 12 only. ovf=0.
- Round-robin order:
  - Stimulus: modes=1, out_ready=1, lines[0], lines[1], lines[3] rise in the same cycle.
  - Required: offers of id 0, 1, 3 in cycles +2, +4, +6.
  - Follow-up: lines[0] and lines[3] rise together (ptr=0).
  - Required: offers of id 0, then 3.
- Pulse mode:
  - Stimulus: mode[1]=3, lines[1] driven with 1001011011110001 from reset release, out_ready=1.
  - Required: detect exactly in cycles 1 and 4, two offers of id 1. No detect on the 11 or 1111 runs.
- Overflow:
  - Stimulus: mode[0]=1, out_ready=0, lines[0] = 0101010.
  - Required: first edge offered with id 0 held. Second edge sets pending. Third edge sets ovf[0]=1.
  - Follow-up: ovf_clr[0] pulse, then out_ready=1.
  - Required: ovf[0]=0, remaining offer delivered.
- Falling and disabled:
  - Stimulus: mode[2]=2, mode[3]=0, both lines 1→0.
  - Required: only id 2 offered. Setting mode[2]=0 while pending[2]=1 clears it with no offer.
- Reset mid-offer:
  - Stimulus: rst=0 asynchronously during OFFER with pending[1] and pending[3] set.
  - Required: out_valid=0 immediately, pending=0, ovf=0, ptr=0. After release, no stale offers.
